hazard_sequencer: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It detects load-use hazards between the ID and EX stages and sequences branch-taken flushes of the IF/ID, ID/EX and EX/DM registers. It freezes the whole pipeline while a data-memory access is not ready. It also keeps saturating stall and flush performance counters and a sticky memory-timeout flag. It sits beside the pipeline registers and drives their write-enable, bubble and flush inputs.

---
 rtl/hazard_sequencer_if.sv | 46 ++++
 rtl/hazard_sequencer.sv | 178 +++++++++++++++++
 tb/tb_hazard_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// Pipeline-side bundle for the hazard sequencer: hazard sources coming in from
// the ID/EX/DM stages and the stall/flush controls plus status going back out.
interface hazard_sequencer_if #(
   parameter int CNT_W = 16
);
   // hazard sources
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic [4:0]       ex_rd;
   logic             ex_mem_read;
   logic             branch_taken_ex;
   logic             dmem_req;
   logic             dmem_ready;
   // pipeline controls
   logic             pc_write;
   logic             if_id_write;
   logic             id_ex_bubble;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_dm_flush;
   logic             pipe_hold;
   // status
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;
   logic             mem_timeout_err;

   // pipeline side: supplies hazard sources, consumes controls
   modport master (
      output id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read,
             branch_taken_ex, dmem_req, dmem_ready,
      input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
             ex_dm_flush, pipe_hold, state, stall_cycles, flush_count,
             mem_timeout_err
   );

   // sequencer side
   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read,
             branch_taken_ex, dmem_req, dmem_ready,
      output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
             ex_dm_flush, pipe_hold, state, stall_cycles, flush_count,
             mem_timeout_err
   );
endinterface

// File: rtl/hazard_sequencer.sv
// Central stall/flush controller for the five-stage pipeline: load-use stalls,
// branch-taken flush sequencing, whole-pipe freeze on data-memory wait with a
// timeout, and saturating stall/flush performance counters.
module hazard_sequencer #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input logic                clk,
   input logic                reset,   // asynchronous, active low
   hazard_sequencer_if.slave  hz
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_MEM_WAIT = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

   state_t           state_reg, state_next;
   logic [7:0]       timer_reg, timer_next;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] flush_cnt_reg;
   logic             err_reg;

   logic             lu;
   logic             ms;
   logic             flush_take;
   logic             timeout_hit;

   logic             pc_write;
   logic             if_id_write;
   logic             id_ex_bubble;
   logic             flush_all;
   logic             pipe_hold;

   // register zero is never a real dependency, so it cannot cause a stall
   assign lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
   assign ms = hz.dmem_req && !hz.dmem_ready;

   // state and wait-timer register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_RUN;
         timer_reg <= 8'd0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
      end
   end

   // next-state: memory stall beats branch beats load-use
   always_comb begin
      state_next  = state_reg;
      timer_next  = timer_reg;
      flush_take  = 1'b0;
      timeout_hit = 1'b0;
      case (state_reg)
         ST_RUN, ST_LU_STALL: begin
            if (ms) begin
               state_next = ST_MEM_WAIT;
               timer_next = 8'd1;
            end else if (hz.branch_taken_ex) begin
               state_next = ST_FLUSH;
               flush_take = 1'b1;
            end else if (lu && (state_reg == ST_RUN)) begin
               state_next = ST_LU_STALL;
            end else begin
               state_next = ST_RUN;
            end
         end
         ST_FLUSH: begin
            // a branch here belongs to a squashed instruction
            if (ms) begin
               state_next = ST_MEM_WAIT;
               timer_next = 8'd1;
            end else begin
               state_next = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            if (hz.dmem_ready) begin
               state_next = ST_RUN;
               timer_next = 8'd0;
            end else if (timer_reg >= TIMEOUT_VAL) begin
               state_next  = ST_RUN;
               timer_next  = 8'd0;
               timeout_hit = 1'b1;
            end else begin
               timer_next = timer_reg + 8'd1;
            end
         end
         default: begin
            state_next = ST_RUN;
            timer_next = 8'd0;
         end
      endcase
   end

   // Mealy controls; everything is held inactive (PC frozen) while in reset
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      flush_all    = 1'b0;
      pipe_hold    = 1'b0;
      case (state_reg)
         ST_RUN, ST_LU_STALL: begin
            if (ms) begin
               pipe_hold   = 1'b1;
               pc_write    = 1'b0;
               if_id_write = 1'b0;
            end else if (hz.branch_taken_ex) begin
               flush_all = 1'b1;
            end else if (lu && (state_reg == ST_RUN)) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
            end
         end
         ST_FLUSH: begin
            id_ex_bubble = 1'b1;
            if (ms) begin
               pipe_hold   = 1'b1;
               pc_write    = 1'b0;
               if_id_write = 1'b0;
            end
         end
         ST_MEM_WAIT: begin
            if (!hz.dmem_ready) begin
               pipe_hold   = 1'b1;
               pc_write    = 1'b0;
               if_id_write = 1'b0;
            end
         end
         default: ;
      endcase
      if (!reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b0;
         flush_all    = 1'b0;
         pipe_hold    = 1'b0;
      end
   end

   // saturating performance counters and sticky timeout flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
         err_reg       <= 1'b0;
      end else begin
         if (!pc_write && !(&stall_cnt_reg))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         if (flush_take && !(&flush_cnt_reg))
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
         if (timeout_hit)
            err_reg <= 1'b1;
      end
   end

   assign hz.pc_write        = pc_write;
   assign hz.if_id_write     = if_id_write;
   assign hz.id_ex_bubble    = id_ex_bubble;
   assign hz.if_id_flush     = flush_all;
   assign hz.id_ex_flush     = flush_all;
   assign hz.ex_dm_flush     = flush_all;
   assign hz.pipe_hold       = pipe_hold;
   assign hz.state           = state_reg;
   assign hz.stall_cycles    = stall_cnt_reg;
   assign hz.flush_count     = flush_cnt_reg;
   assign hz.mem_timeout_err = err_reg;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed-vector bench for hazard_sequencer (CNT_W=4, MEM_TIMEOUT=4).
// The driver applies one input vector per cycle and queues the expected
// outputs for that cycle; the monitor compares them at the falling edge.
module tb_hazard_sequencer;

   localparam int CNT_W = 4;

   logic clk;
   logic reset;

   hazard_sequencer_if #(.CNT_W(CNT_W)) hz ();

   hazard_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   string       name_q[$];
   logic [17:0] exp_q[$];
   int          checks;
   int          passes;

   // expected word: {pc, ifw, bubble, 3x flush, hold, state, err, stall, flush_cnt}
   function automatic logic [17:0] pk(input logic pc, input logic ifw, input logic bub,
                                      input logic fl, input logic hold, input logic [1:0] st,
                                      input logic err, input logic [3:0] sc, input logic [3:0] fc);
      return {pc, ifw, bub, fl, fl, fl, hold, st, err, sc, fc};
   endfunction

   function automatic logic [17:0] actual();
      return {hz.pc_write, hz.if_id_write, hz.id_ex_bubble, hz.if_id_flush, hz.id_ex_flush,
              hz.ex_dm_flush, hz.pipe_hold, hz.state, hz.mem_timeout_err,
              hz.stall_cycles, hz.flush_count};
   endfunction

   task automatic cyc(input string nm, input logic rn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                      input logic [4:0] rd, input logic mr, input logic br,
                      input logic rq, input logic ry, input logic [17:0] e);
      @(posedge clk);
      #1;
      reset              = rn;
      hz.id_rs           = rs;
      hz.id_rt           = rt;
      hz.id_uses_rt      = ur;
      hz.ex_rd           = rd;
      hz.ex_mem_read     = mr;
      hz.branch_taken_ex = br;
      hz.dmem_req        = rq;
      hz.dmem_ready      = ry;
      name_q.push_back(nm);
      exp_q.push_back(e);
   endtask

   // monitor: one comparison per queued cycle
   initial begin
      string       nm;
      logic [17:0] e;
      logic [17:0] a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            nm = name_q.pop_front();
            e  = exp_q.pop_front();
            a  = actual();
            checks++;
            if (a === e) begin
               passes++;
               $display("ok   %-18s outputs=%05h", nm, a);
            end else begin
               $display("FAIL %-18s got=%05h want=%05h", nm, a, e);
            end
         end
      end
   end

   initial begin
      checks = 0;
      passes = 0;
      reset  = 1'b1;
      hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0; hz.ex_rd = 5'd0;
      hz.ex_mem_read = 1'b0; hz.branch_taken_ex = 1'b0;
      hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
      #3 reset = 1'b0;

      //   name               rn rs rt ur rd mr br rq ry   pc ifw bub fl hold st err sc fc
      cyc("reset",            0, 0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc("run_idle",         1, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      // load-use on rs
      cyc("lu_detect",        1, 5, 0, 0, 5, 1, 0, 0, 0, pk(0, 0, 1, 0, 0, 0, 0, 0, 0));
      cyc("lu_stall_state",   1, 5, 0, 0, 5, 1, 0, 0, 0, pk(1, 1, 0, 0, 0, 1, 0, 1, 0));
      cyc("lu_done",          1, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 0, 1, 0));
      // no-stall corner cases, then an rt stall
      cyc("rd0_nostall",      1, 0, 0, 1, 0, 1, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 0, 1, 0));
      cyc("rt_unused",        1, 3, 7, 0, 7, 1, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 0, 1, 0));
      cyc("rt_stall",         1, 3, 7, 1, 7, 1, 0, 0, 0, pk(0, 0, 1, 0, 0, 0, 0, 1, 0));
      cyc("rt_stall_state",   1, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 1, 0, 2, 0));
      // branch flush; branch still high in FLUSH is ignored
      cyc("br_flush",         1, 0, 0, 0, 0, 0, 1, 0, 0, pk(1, 1, 0, 1, 0, 0, 0, 2, 0));
      cyc("br_flush_state",   1, 0, 0, 0, 0, 0, 1, 0, 0, pk(1, 1, 1, 0, 0, 2, 0, 2, 1));
      cyc("br_done",          1, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 0, 2, 1));
      // memory wait with branch and load-use pending: only ms acts
      cyc("ms_entry",         1, 5, 0, 0, 5, 1, 1, 1, 0, pk(0, 0, 0, 0, 1, 0, 0, 2, 1));
      cyc("mw_wait1",         1, 5, 0, 0, 5, 1, 1, 1, 0, pk(0, 0, 0, 0, 1, 3, 0, 3, 1));
      cyc("mw_wait2",         1, 5, 0, 0, 5, 1, 1, 1, 0, pk(0, 0, 0, 0, 1, 3, 0, 4, 1));
      cyc("mw_ready",         1, 5, 0, 0, 5, 1, 1, 1, 1, pk(1, 1, 0, 0, 0, 3, 0, 5, 1));
      cyc("br_after_mw",      1, 5, 0, 0, 5, 1, 1, 0, 0, pk(1, 1, 0, 1, 0, 0, 0, 5, 1));
      cyc("br_after_mw_fl",   1, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 1, 0, 0, 2, 0, 5, 2));
      cyc("run_again",        1, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 0, 5, 2));
      // timeout after four MEM_WAIT cycles
      cyc("to_entry",         1, 0, 0, 0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 1, 0, 0, 5, 2));
      cyc("to_wait1",         1, 0, 0, 0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 1, 3, 0, 6, 2));
      cyc("to_wait2",         1, 0, 0, 0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 1, 3, 0, 7, 2));
      cyc("to_wait3",         1, 0, 0, 0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 1, 3, 0, 8, 2));
      cyc("to_wait4",         1, 0, 0, 0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 1, 3, 0, 9, 2));
      cyc("timeout_flag",     1, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 1, 10, 2));
      cyc("err_sticky",       1, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 1, 10, 2));
      // asynchronous reset in the middle of a memory wait
      cyc("rst_mw_entry",     1, 0, 0, 0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 1, 0, 1, 10, 2));
      cyc("rst_mw_wait",      1, 0, 0, 0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 1, 3, 1, 11, 2));
      cyc("reset_mid_mw",     0, 0, 0, 0, 0, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc("after_reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      // continuous memory stall: entry + 4 waits + timeout repeat; counter saturates at 15
      for (int k = 0; k < 22; k++) begin
         cyc("sat_stall", 1, 0, 0, 0, 0, 0, 0, 1, 0,
             pk(0, 0, 0, 0, 1, ((k % 5) == 0) ? 2'd0 : 2'd3, (k >= 5) ? 1'b1 : 1'b0,
                (k > 15) ? 4'd15 : 4'(k), 0));
      end
      cyc("sat_ready",        1, 0, 0, 0, 0, 0, 0, 1, 1, pk(1, 1, 0, 0, 0, 3, 1, 15, 0));
      cyc("sat_hold",         1, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 1, 15, 0));

      repeat (3) @(posedge clk);
      if (exp_q.size() > 0) begin
         $display("FAIL drain             got=%0d unchecked want=0", exp_q.size());
         checks += exp_q.size();
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
